// File: rtl/inertial_integrator_cal.sv
// inertial_integrator_cal
//   Complementary-filter pitch estimator. The gyro rate, with its offset
//   removed, is integrated into a saturating fixed-point accumulator. Each
//   integrated sample is also pulled one fusion step toward the pitch derived
//   from the accelerometer. A calibration mode averages 2**CAL_LOG2 raw gyro
//   samples to find a new gyro offset. When calibration finishes, the pitch is
//   re-seeded from the accelerometer.
// Ports
//   clk, rst_n      clock, async active-low reset
//   vld             new sample on ptch_rt / AZ
//   ptch_rt         signed gyro pitch rate
//   AZ              Z accelerometer reading
//   cal_req         pulse: start offset calibration
//   ptch            signed fused pitch (integer part of the integrator)
//   ptch_vld        strobe: ptch updated on the previous edge
//   cal_busy        calibration in progress
//   cal_done        strobe: new offset loaded on the previous edge
//   ptch_rt_offset  current gyro offset
module inertial_integrator_cal #(
  parameter int                DATA_W             = 16,
  parameter int                FRAC_W             = 11,
  parameter logic [DATA_W-1:0] AZ_OFFSET          = 16'hFE80,
  parameter logic [DATA_W-1:0] PTCH_RT_OFFSET_RST = 16'h03C2,
  parameter int                ACC_GAIN           = 327,
  parameter int                ACC_SHIFT          = 13,
  parameter int                FUSION_STEP        = 1024,
  parameter int                CAL_LOG2           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic [DATA_W-1:0] ptch_rt,
  input  logic [DATA_W-1:0] AZ,
  input  logic              cal_req,
  output logic [DATA_W-1:0] ptch,
  output logic              ptch_vld,
  output logic              cal_busy,
  output logic              cal_done,
  output logic [DATA_W-1:0] ptch_rt_offset
);

  localparam int INT_W = DATA_W + FRAC_W;
  localparam int ACC_W = DATA_W + CAL_LOG2;
  localparam int PRD_W = 2*DATA_W + 1;

  localparam logic signed [DATA_W:0]  GAIN_S  = (DATA_W+1)'(ACC_GAIN);
  localparam logic signed [INT_W-1:0] FUS_P   = INT_W'(FUSION_STEP);
  localparam logic signed [INT_W-1:0] FUS_N   = -FUS_P;
  localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic {RUN, CAL} state_t;

  state_t                    state;
  logic signed [INT_W-1:0]   ptch_int;
  logic signed [INT_W-1:0]   fusion;
  logic        [CAL_LOG2:0]  cal_cnt;
  logic signed [ACC_W-1:0]   cal_acc;

  // Accelerometer pitch. az_c is taken mod 2**DATA_W. Both product operands
  // are widened to the full product width so the multiply cannot overflow.
  logic signed [DATA_W-1:0] az_c;
  logic signed [PRD_W-1:0]  az_prod;
  logic signed [PRD_W-1:0]  az_shf;
  logic signed [DATA_W-1:0] ptch_acc;
  logic signed [DATA_W-1:0] ptch_s;

  assign az_c     = AZ - AZ_OFFSET;
  assign az_prod  = $signed({{(DATA_W+1){az_c[DATA_W-1]}}, az_c}) *
                    $signed({{DATA_W{GAIN_S[DATA_W]}}, GAIN_S});
  assign az_shf   = az_prod >>> ACC_SHIFT;
  assign ptch_acc = az_shf[DATA_W-1:0];
  assign ptch_s   = ptch_int[INT_W-1:FRAC_W];
  assign ptch     = ptch_s;

  // The offset-corrected rate gets one extra bit so a full-scale rate minus
  // any offset cannot wrap.
  logic signed [DATA_W:0] rt_c;
  assign rt_c = {ptch_rt[DATA_W-1], ptch_rt} -
                {ptch_rt_offset[DATA_W-1], ptch_rt_offset};

  // The integrator sum uses two guard bits. If the top three bits disagree,
  // the result has left the INT_W range and is clamped.
  logic signed [INT_W+1:0] sum;
  logic signed [INT_W-1:0] sum_sat;
  assign sum = {{2{ptch_int[INT_W-1]}}, ptch_int}
             - {{(INT_W+1-DATA_W){rt_c[DATA_W]}}, rt_c}
             + {{2{fusion[INT_W-1]}}, fusion};

  always_comb begin
    sum_sat = sum[INT_W-1:0];
    if (sum[INT_W+1:INT_W-1] != 3'b000 && sum[INT_W+1:INT_W-1] != 3'b111)
      sum_sat = sum[INT_W+1] ? INT_MIN : INT_MAX;
  end

  // Calibration accumulator. cnt_next reaching 2**CAL_LOG2 sets its MSB.
  // acc >>> CAL_LOG2 is simply the upper DATA_W bits of the accumulator,
  // which rounds toward -inf.
  logic signed [ACC_W-1:0] acc_next;
  logic        [CAL_LOG2:0] cnt_next;
  assign acc_next = cal_acc + {{CAL_LOG2{ptch_rt[DATA_W-1]}}, ptch_rt};
  assign cnt_next = cal_cnt + (CAL_LOG2+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      ptch_int       <= '0;
      fusion         <= '0;
      ptch_rt_offset <= PTCH_RT_OFFSET_RST;
      ptch_vld       <= 1'b0;
      cal_busy       <= 1'b0;
      cal_done       <= 1'b0;
      cal_cnt        <= '0;
      cal_acc        <= '0;
    end else begin
      // The correction direction is tracked every clock, even while calibrating.
      fusion   <= (ptch_acc > ptch_s) ? FUS_P : FUS_N;
      ptch_vld <= 1'b0;
      cal_done <= 1'b0;
      case (state)
        RUN: begin
          if (vld) begin
            ptch_int <= sum_sat;
            ptch_vld <= 1'b1;
          end
          if (cal_req) begin
            state    <= CAL;
            cal_busy <= 1'b1;
            cal_cnt  <= '0;
            cal_acc  <= '0;
          end
        end
        CAL: begin
          if (vld) begin
            cal_acc <= acc_next;
            cal_cnt <= cnt_next;
            if (cnt_next[CAL_LOG2]) begin
              ptch_rt_offset <= acc_next[ACC_W-1:CAL_LOG2];
              ptch_int       <= {ptch_acc, {FRAC_W{1'b0}}};
              state          <= RUN;
              cal_busy       <= 1'b0;
              cal_done       <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// Bench for inertial_integrator_cal (CAL_LOG2 = 4). A table of per-clock
// vectors with hand-computed expected values is applied from reset. After it
// come directed sequences for calibration, async reset, zero and constant
// rate, saturation, and reset during calibration.
module tb_inertial_integrator_cal;

  logic        clk = 1'b0;
  logic        rst_n, vld, cal_req;
  logic [15:0] ptch_rt, AZ;
  logic [15:0] ptch, ptch_rt_offset;
  logic        ptch_vld, cal_busy, cal_done;

  inertial_integrator_cal #(.CAL_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ),
    .cal_req(cal_req), .ptch(ptch), .ptch_vld(ptch_vld), .cal_busy(cal_busy),
    .cal_done(cal_done), .ptch_rt_offset(ptch_rt_offset)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input logic cond);
    n_chk++;
    if (cond !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: condition got %b expected 1", name, cond);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld = 1'b0; cal_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        vld;
    logic        cal_req;
    logic [15:0] rt;
    logic [15:0] az;
    logic [15:0] e_ptch;
    logic        e_pv;
    logic        e_busy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic signed [15:0] prev, cur;
    logic ok_mono, ok_pv, ok_rng, ok_busy, ok_frz;
    AZ = 16'hFE80; ptch_rt = 16'h03C2;

    // Per-clock vectors from reset. AZ FE80 gives an accel pitch of 0, 0E80
    // gives +163 and EE80 gives -164. Rate 0BC2 gives rt_c = 2048.
    tbl[0]  = '{0,0,16'h03C2,16'hFE80,16'h0000,0,0};
    tbl[1]  = '{1,0,16'h03C2,16'hFE80,16'hFFFF,1,0};
    tbl[2]  = '{0,0,16'h03C2,16'hFE80,16'hFFFF,0,0};
    tbl[3]  = '{1,0,16'h03C2,16'hFE80,16'h0000,1,0};
    tbl[4]  = '{1,0,16'h03C2,16'hFE80,16'h0000,1,0};
    tbl[5]  = '{1,0,16'h03C2,16'hFE80,16'h0000,1,0};
    tbl[6]  = '{1,0,16'h0BC2,16'hFE80,16'hFFFE,1,0};
    tbl[7]  = '{1,0,16'h0BC2,16'hFE80,16'hFFFD,1,0};
    tbl[8]  = '{1,0,16'h0BC2,16'hFE80,16'hFFFC,1,0};
    tbl[9]  = '{1,0,16'h03C2,16'h0E80,16'hFFFD,1,0};
    tbl[10] = '{1,0,16'h03C2,16'h0E80,16'hFFFD,1,0};
    tbl[11] = '{0,0,16'h03C2,16'hEE80,16'hFFFD,0,0};
    tbl[12] = '{1,0,16'h03C2,16'hEE80,16'hFFFD,1,0};
    tbl[13] = '{1,1,16'h03C2,16'hEE80,16'hFFFC,1,1};  // vld + cal_req: still integrated
    tbl[14] = '{0,0,16'h03C2,16'hEE80,16'hFFFC,0,1};
    tbl[15] = '{1,0,16'h03C2,16'hEE80,16'hFFFC,0,1};  // CAL: ptch frozen

    do_reset();
    chk("rst_ptch", ptch, 16'h0000);
    chk("rst_pv", {15'd0, ptch_vld}, 16'd0);
    chk("rst_busy", {15'd0, cal_busy}, 16'd0);
    chk("rst_done", {15'd0, cal_done}, 16'd0);
    chk("rst_off", ptch_rt_offset, 16'h03C2);

    for (int i = 0; i < 16; i++) begin
      vld = tbl[i].vld; cal_req = tbl[i].cal_req;
      ptch_rt = tbl[i].rt; AZ = tbl[i].az;
      tick();
      chk($sformatf("vec%0d_ptch", i), ptch, tbl[i].e_ptch);
      chk($sformatf("vec%0d_pv", i), {15'd0, ptch_vld}, {15'd0, tbl[i].e_pv});
      chk($sformatf("vec%0d_busy", i), {15'd0, cal_busy}, {15'd0, tbl[i].e_busy});
    end

    // Calibration: 15 x 0400 and 1 x 040F average to 0400 (rounded down).
    // Accel pitch 0 seeds ptch = 0.
    do_reset();
    AZ = 16'hFE80;
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    chk("calA_busy0", {15'd0, cal_busy}, 16'd1);
    ok_pv = 1'b1; ok_busy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ptch_rt = (k == 15) ? 16'h040F : 16'h0400;
      vld = 1'b1; tick(); vld = 1'b0;
      if (ptch_vld) ok_pv = 1'b0;
      if (k < 15) begin
        if (!cal_busy || cal_done) ok_busy = 1'b0;
        tick();
        if (ptch_vld || !cal_busy || cal_done) ok_busy = 1'b0;
      end
    end
    chk("calA_done", {15'd0, cal_done}, 16'd1);
    chk("calA_busy_end", {15'd0, cal_busy}, 16'd0);
    chk("calA_off", ptch_rt_offset, 16'h0400);
    chk("calA_ptch", ptch, 16'h0000);
    chk_true("calA_no_pv", ok_pv);
    chk_true("calA_busy_window", ok_busy);
    tick();
    chk("calA_done_1clk", {15'd0, cal_done}, 16'd0);

    // Calibration with a negative average: -1/16 rounds to FFFF. A mid-run
    // cal_req is ignored, and the accel pitch (-164) seeds ptch.
    AZ = 16'hEE80;
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    ok_frz = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ptch_rt = (k == 0) ? 16'hFFFF : 16'h0000;
      cal_req = (k == 5);
      vld = 1'b1; tick(); vld = 1'b0; cal_req = 1'b0;
      if (k < 15 && (ptch !== 16'h0000 || cal_done)) ok_frz = 1'b0;
    end
    chk_true("calB_frozen", ok_frz);
    chk("calB_done", {15'd0, cal_done}, 16'd1);
    chk("calB_off", ptch_rt_offset, 16'hFFFF);
    chk("calB_ptch", ptch, 16'hFF5C);

    // Asynchronous reset applied mid-cycle while calibrating.
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0; #1;
    chk("arst_ptch", ptch, 16'h0000);
    chk("arst_pv", {15'd0, ptch_vld}, 16'd0);
    chk("arst_busy", {15'd0, cal_busy}, 16'd0);
    chk("arst_off", ptch_rt_offset, 16'h03C2);
    tick(); rst_n = 1'b1;

    // Zero rate: ptch stays in {-1, 0}.
    do_reset();
    AZ = 16'hFE80; ptch_rt = 16'h03C2;
    ok_pv = 1'b1; ok_rng = 1'b1;
    for (int k = 0; k < 200; k++) begin
      vld = 1'b1; tick(); vld = 1'b0;
      if (!ptch_vld) ok_pv = 1'b0;
      if (ptch !== 16'h0000 && ptch !== 16'hFFFF) ok_rng = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        if (ptch_vld) ok_pv = 1'b0;
      end
    end
    chk_true("zero_pv_strobe", ok_pv);
    chk_true("zero_range", ok_rng);

    // Constant rate of 2048 LSB per sample against the +1024 correction.
    do_reset();
    ptch_rt = 16'h0BC2;
    ok_mono = 1'b1; prev = '0;
    for (int k = 0; k < 64; k++) begin
      vld = 1'b1; tick(); vld = 1'b0; tick();
      cur = ptch;
      if (cur > prev) ok_mono = 1'b0;
      prev = cur;
    end
    chk_true("const_mono", ok_mono);
    chk_true("const_final", (cur >= -16'sd33) && (cur <= -16'sd31));

    // Positive saturation, then negative saturation.
    do_reset();
    ptch_rt = 16'h8000;
    ok_mono = 1'b1; prev = '0;
    vld = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      tick(); cur = ptch;
      if (cur < prev) ok_mono = 1'b0;
      prev = cur;
    end
    chk_true("sat_pos_nowrap", ok_mono);
    chk("sat_pos_max", ptch, 16'h7FFF);
    ptch_rt = 16'h7FFF;
    for (int k = 0; k < 5000; k++) tick();
    chk("sat_neg_min", ptch, 16'h8000);
    vld = 1'b0;

    // Reset during calibration discards the partial count.
    do_reset();
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    ptch_rt = 16'h0100;
    for (int k = 0; k < 5; k++) begin vld = 1'b1; tick(); vld = 1'b0; end
    @(posedge clk); #3 rst_n = 1'b0; #1;
    chk("rmc_busy", {15'd0, cal_busy}, 16'd0);
    chk("rmc_off", ptch_rt_offset, 16'h03C2);
    tick(); rst_n = 1'b1;
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    ptch_rt = 16'h0200;
    ok_busy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      vld = 1'b1; tick(); vld = 1'b0;
      if (k < 15 && (cal_done || !cal_busy)) ok_busy = 1'b0;
    end
    chk_true("rmc_full_count", ok_busy);
    chk("rmc_done", {15'd0, cal_done}, 16'd1);
    chk("rmc_off_new", ptch_rt_offset, 16'h0200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
